id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline stage between instruction decode and the ALU in the 5-stage MIPS datapath.
- Registers the decoded operands and control signals, and forwards operands from EX/MEM and MEM/WB.
- Drives the ALU operand and control ports: src1, src2 and the 4-bit ALU control (ADD 0000, OR 0001, AND 0010, SUB 0110, SLT 0111, MUL 1000, LW 1001, SW 1010, LUI 1011).
- Detects load-use hazards, inserts bubbles, and honours stall and flush from the hazard and branch logic.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width
IMM_W, 16, immediate width

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_n_i  in  1  reset, synchronous, active-low
stall_i  in  1  hold all stage registers
flush_i  in  1  replace stage contents with a bubble
valid_i  in  1  decode slot holds a real instruction
rs_addr_i  in  5  decode source register 1
rt_addr_i  in  5  decode source register 2
rd_addr_i  in  5  decode destination register
rs_data_i  in  32  register file read data for rs
rt_data_i  in  32  register file read data for rt
imm_i  in  16  raw immediate
ext_op_i  in  1  1 = sign-extend, 0 = zero-extend
alu_src_i  in  1  1 = src2 is the immediate, 0 = src2 is rt
uses_rt_i  in  1  instruction reads rt (R-type, SW, branches)
alu_ctrl_i  in  4  ALU control code
reg_write_i  in  1  instruction writes rd
mem_read_i  in  1  load
mem_write_i  in  1  store
exmem_reg_write_i  in  1  EX/MEM stage writes a register
exmem_rd_i  in  5  EX/MEM destination register
exmem_result_i  in  32  EX/MEM ALU result
memwb_reg_write_i  in  1  MEM/WB stage writes a register
memwb_rd_i  in  5  MEM/WB destination register
memwb_result_i  in  32  MEM/WB write-back data
valid_o  out  1  stage holds a real instruction
src1_o  out  32  ALU operand 1 (forwarded)
src2_o  out  32  ALU operand 2 (immediate or forwarded rt)
store_data_o  out  32  forwarded rt value for SW
alu_ctrl_o  out  4  registered ALU control
rd_addr_o  out  5  registered destination
reg_write_o, mem_read_o, mem_write_o  out  1 each  registered controls, forced to 0 when valid_o = 0
stall_req_o  out  1  load-use hazard, combinational; upstream holds PC and IF/ID

Behaviour:
- Reset (rst_n_i = 0 at an edge) clears all registers: valid_o = 0, all control outputs 0, alu_ctrl_o = 0000, rd_addr_o = 0, stored data 0.
- Per-edge priority: reset > flush_i > stall_i > load-use bubble > capture.
  - Flush: stage becomes a bubble (valid, reg_write, mem_read, mem_write = 0; data don't-care).
  - Stall: all registers hold.
  - Load-use bubble: stage becomes a bubble. Upstream holds via stall_req_o, so the held instruction is captured on the following edge.
  - Capture: the input set is registered; latency from decode to ALU inputs is 1 cycle.
- stall_req_o = valid_o & mem_read_o & (rd_addr_o != 0) & ((rd_addr_o == rs_addr_i) | (uses_rt_i & rd_addr_o == rt_addr_i)). It is not gated by valid_i.
- Capture-time write-back bypass: if memwb_reg_write_i, memwb_rd_i != 0 and memwb_rd_i == rs_addr_i (or rt_addr_i), the stored value is memwb_result_i instead of the register file data.
- Immediate: the extended value is {16{imm[15]}}:imm if ext_op_i, else {16'd0, imm}. The stored immediate for LUI (alu_ctrl_i = 1011) is {imm, 16'd0}, regardless of ext_op_i.
- Forwarding is combinational on the outputs, applied per operand (rs and rt):
  - Use exmem_result_i if exmem_reg_write_i, exmem_rd_i != 0 and it matches.
  - Else use memwb_result_i on the same conditions.
  - Else use the stored value.
  - EX/MEM has priority when both stages match. Register 0 is never forwarded.
- src2_o = stored immediate if the stored alu_src is set, else forwarded rt. store_data_o is always forwarded rt.
- With valid_o = 0, forwarding still computes, but the controls are 0, so no architectural effect.
- Reset during stall or flush: reset wins. stall_req_o is 0 in the cycle after reset.

Test Plan:
1. Reset then capture ADD: rs = 3 (data 5), rt = 4 (data 7), alu_src = 0 -> after 1 edge valid_o = 1, src1_o = 5, src2_o = 7, alu_ctrl_o = 0000.
2. Forward priority: stored rs = 8. exmem_rd = 8 with result 0x11 and memwb_rd = 8 with result 0x22 -> src1_o = 0x11. Drop exmem_reg_write -> 0x22. Set rd = 0 on both -> stored value.
3. Load-use: LW to r9 in stage, decode ADD rs = 9 -> stall_req_o = 1. Next edge valid_o = 0, reg_write_o = 0. Next edge ADD is captured, and src1_o follows memwb_result_i when memwb_rd = 9.
4. Immediates: imm = 0x8001 with ext_op = 1 -> src2_o = 0xFFFF8001. With ext_op = 0 -> 0x00008001. LUI with imm = 0x1234 -> 0x12340000.
5. Stall with flush: stall_i held 3 cycles -> outputs unchanged. flush_i and stall_i together -> bubble next edge.
6. Write-back bypass at capture: rs_data_i = 0, memwb writes rs = 5 with 0xAB in the capture cycle -> src1_o = 0xAB after the edge with no forwarding active.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// Holds decoded operands, forwards from EX/MEM and MEM/WB, and raises load-use stalls.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic              ext_op_i,
  input  logic              alu_src_i,
  input  logic              uses_rt_i,
  input  logic [3:0]        alu_ctrl_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [3:0]        alu_ctrl_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              stall_req_o
);

  localparam logic [3:0] ALU_LUI = 4'b1011;
  localparam int         PAD     = DATA_W - IMM_W;

  logic              valid_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rs_val_q;
  logic [DATA_W-1:0] rt_val_q;
  logic [DATA_W-1:0] imm_q;
  logic              alu_src_q;
  logic [3:0]        alu_ctrl_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic              load_use;
  logic              wb_rs_hit;
  logic              wb_rt_hit;
  logic [DATA_W-1:0] rs_cap;
  logic [DATA_W-1:0] rt_cap;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] imm_cap;

  assign load_use = valid_q & mem_read_q & (rd_q != '0) &
                    ((rd_q == rs_addr_i) |
                     (uses_rt_i & (rd_q == rt_addr_i)));

  // Register file is read before this cycle's write-back lands
  assign wb_rs_hit = memwb_reg_write_i & (memwb_rd_i != '0) &
                     (memwb_rd_i == rs_addr_i);
  assign wb_rt_hit = memwb_reg_write_i & (memwb_rd_i != '0) &
                     (memwb_rd_i == rt_addr_i);
  assign rs_cap = wb_rs_hit ? memwb_result_i : rs_data_i;
  assign rt_cap = wb_rt_hit ? memwb_result_i : rt_data_i;

  assign imm_ext = ext_op_i ? {{PAD{imm_i[IMM_W-1]}}, imm_i}
                            : {{PAD{1'b0}}, imm_i};
  assign imm_cap = (alu_ctrl_i == ALU_LUI) ? {imm_i, {PAD{1'b0}}}
                                           : imm_ext;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (flush_i || (!stall_i && load_use)) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q     <= valid_i;
      rs_q        <= rs_addr_i;
      rt_q        <= rt_addr_i;
      rd_q        <= rd_addr_i;
      rs_val_q    <= rs_cap;
      rt_val_q    <= rt_cap;
      imm_q       <= imm_cap;
      alu_src_q   <= alu_src_i;
      alu_ctrl_q  <= alu_ctrl_i;
      reg_write_q <= valid_i & reg_write_i;
      mem_read_q  <= valid_i & mem_read_i;
      mem_write_q <= valid_i & mem_write_i;
    end
  end

  logic ex_rs_hit;
  logic ex_rt_hit;
  logic mw_rs_hit;
  logic mw_rt_hit;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  // EX/MEM is the younger producer, so it wins over MEM/WB
  assign ex_rs_hit = exmem_reg_write_i & (exmem_rd_i != '0) &
                     (exmem_rd_i == rs_q);
  assign ex_rt_hit = exmem_reg_write_i & (exmem_rd_i != '0) &
                     (exmem_rd_i == rt_q);
  assign mw_rs_hit = memwb_reg_write_i & (memwb_rd_i != '0) &
                     (memwb_rd_i == rs_q);
  assign mw_rt_hit = memwb_reg_write_i & (memwb_rd_i != '0) &
                     (memwb_rd_i == rt_q);

  assign rs_fwd = ex_rs_hit ? exmem_result_i :
                  mw_rs_hit ? memwb_result_i : rs_val_q;
  assign rt_fwd = ex_rt_hit ? exmem_result_i :
                  mw_rt_hit ? memwb_result_i : rt_val_q;

  assign valid_o      = valid_q;
  assign src1_o       = rs_fwd;
  assign src2_o       = alu_src_q ? imm_q : rt_fwd;
  assign store_data_o = rt_fwd;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign rd_addr_o    = rd_q;
  assign reg_write_o  = valid_q & reg_write_q;
  assign mem_read_o   = valid_q & mem_read_q;
  assign mem_write_o  = valid_q & mem_write_q;
  assign stall_req_o  = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage.
// Directed vector table, hand sequences, then random traffic against a model.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        stall_i;
  logic        flush_i;
  logic        valid_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic [15:0] imm_i;
  logic        ext_op_i;
  logic        alu_src_i;
  logic        uses_rt_i;
  logic [3:0]  alu_ctrl_i;
  logic        reg_write_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        exmem_reg_write_i;
  logic [4:0]  exmem_rd_i;
  logic [31:0] exmem_result_i;
  logic        memwb_reg_write_i;
  logic [4:0]  memwb_rd_i;
  logic [31:0] memwb_result_i;
  logic        valid_o;
  logic [31:0] src1_o;
  logic [31:0] src2_o;
  logic [31:0] store_data_o;
  logic [3:0]  alu_ctrl_o;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        stall_req_o;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rd_addr_i(rd_addr_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .imm_i(imm_i), .ext_op_i(ext_op_i),
    .alu_src_i(alu_src_i), .uses_rt_i(uses_rt_i),
    .alu_ctrl_i(alu_ctrl_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i),
    .exmem_reg_write_i(exmem_reg_write_i),
    .exmem_rd_i(exmem_rd_i),
    .exmem_result_i(exmem_result_i),
    .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_rd_i(memwb_rd_i),
    .memwb_result_i(memwb_result_i),
    .valid_o(valid_o), .src1_o(src1_o), .src2_o(src2_o),
    .store_data_o(store_data_o), .alu_ctrl_o(alu_ctrl_o),
    .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .stall_req_o(stall_req_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    rst_n_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    valid_i = 1'b0; rs_addr_i = '0; rt_addr_i = '0;
    rd_addr_i = '0; rs_data_i = '0; rt_data_i = '0;
    imm_i = '0; ext_op_i = 1'b0; alu_src_i = 1'b0;
    uses_rt_i = 1'b0; alu_ctrl_i = '0; reg_write_i = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    exmem_reg_write_i = 1'b0; exmem_rd_i = '0;
    exmem_result_i = '0; memwb_reg_write_i = 1'b0;
    memwb_rd_i = '0; memwb_result_i = '0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [31:0] rsd,
                       input logic [4:0] rt, input logic [31:0] rtd,
                       input logic [4:0] rd, input logic [3:0] ctrl,
                       input logic mr);
    valid_i = 1'b1; rs_addr_i = rs; rs_data_i = rsd;
    rt_addr_i = rt; rt_data_i = rtd; rd_addr_i = rd;
    alu_ctrl_i = ctrl; mem_read_i = mr; reg_write_i = 1'b1;
    mem_write_i = 1'b0; uses_rt_i = 1'b1; alu_src_i = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsv, rtv, imm;
    logic        asrc;
    logic [3:0]  ctrl;
    logic        rw, mr, mw;
  } m_t;

  m_t m;

  function automatic logic [31:0] rf_read(input logic [4:0] a,
                                          input logic [31:0] d);
    if (memwb_reg_write_i && memwb_rd_i != 0 && memwb_rd_i == a)
      return memwb_result_i;
    return d;
  endfunction

  function automatic logic [31:0] fwd_exp(input logic [4:0] a,
                                          input logic [31:0] s);
    if (a == 0) return s;
    if (exmem_reg_write_i && exmem_rd_i == a) return exmem_result_i;
    if (memwb_reg_write_i && memwb_rd_i == a) return memwb_result_i;
    return s;
  endfunction

  function automatic logic hazard_exp();
    if (!(m.v && m.mr) || m.rd == 0) return 1'b0;
    return (m.rd == rs_addr_i) || (uses_rt_i && m.rd == rt_addr_i);
  endfunction

  function automatic m_t model_next();
    m_t n = m;
    if (!rst_n_i) begin
      n = '0;
    end else if (flush_i || (!stall_i && hazard_exp())) begin
      n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0;
    end else if (!stall_i) begin
      n.v = valid_i; n.rs = rs_addr_i; n.rt = rt_addr_i;
      n.rd = rd_addr_i;
      n.rsv = rf_read(rs_addr_i, rs_data_i);
      n.rtv = rf_read(rt_addr_i, rt_data_i);
      if (alu_ctrl_i == 4'b1011) n.imm = 32'(imm_i) << 16;
      else if (ext_op_i) n.imm = 32'($signed(imm_i));
      else n.imm = 32'(imm_i);
      n.asrc = alu_src_i; n.ctrl = alu_ctrl_i;
      n.rw = valid_i & reg_write_i;
      n.mr = valid_i & mem_read_i;
      n.mw = valid_i & mem_write_i;
    end
    return n;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic        ext, asrc;
    logic [3:0]  ctrl;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbres;
    logic [31:0] e1, e2, es;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{5'd3, 5'd4, 32'd5, 32'd7, 16'h0, 1'b0, 1'b0, 4'b0000,
              1'b0, 5'd0, 32'h0, 32'd5, 32'd7, 32'd7};
    vt[1] = '{5'd1, 5'd2, 32'h10, 32'h99, 16'h8001, 1'b1, 1'b1,
              4'b0000, 1'b0, 5'd0, 32'h0,
              32'h10, 32'hFFFF8001, 32'h99};
    vt[2] = '{5'd1, 5'd2, 32'h10, 32'h99, 16'h8001, 1'b0, 1'b1,
              4'b0000, 1'b0, 5'd0, 32'h0,
              32'h10, 32'h00008001, 32'h99};
    vt[3] = '{5'd1, 5'd2, 32'h3, 32'h4, 16'h1234, 1'b1, 1'b1,
              4'b1011, 1'b0, 5'd0, 32'h0,
              32'h3, 32'h12340000, 32'h4};
    vt[4] = '{5'd5, 5'd6, 32'h0, 32'h66, 16'h0, 1'b0, 1'b0,
              4'b0110, 1'b1, 5'd5, 32'hAB,
              32'hAB, 32'h66, 32'h66};
    vt[5] = '{5'd2, 5'd7, 32'h22, 32'h1, 16'h0, 1'b0, 1'b0,
              4'b0111, 1'b1, 5'd7, 32'hCD,
              32'h22, 32'hCD, 32'hCD};
    vt[6] = '{5'd0, 5'd2, 32'h5, 32'h9, 16'h0, 1'b0, 1'b0,
              4'b0001, 1'b1, 5'd0, 32'hEE,
              32'h5, 32'h9, 32'h9};

    idle();
    rst_n_i = 1'b0;
    tick(); tick();
    rst_n_i = 1'b1;
    #1;
    chk("rst valid", valid_o, 0);
    chk("rst reg_write", reg_write_o, 0);
    chk("rst mem_read", mem_read_o, 0);
    chk("rst mem_write", mem_write_o, 0);
    chk("rst alu_ctrl", alu_ctrl_o, 0);
    chk("rst rd", rd_addr_o, 0);
    chk("rst src1", src1_o, 0);
    chk("rst stall_req", stall_req_o, 0);

    for (int i = 0; i < 7; i++) begin
      issue(vt[i].rs, vt[i].rsd, vt[i].rt, vt[i].rtd, 5'd10,
            vt[i].ctrl, 1'b0);
      imm_i = vt[i].imm; ext_op_i = vt[i].ext;
      alu_src_i = vt[i].asrc;
      memwb_reg_write_i = vt[i].wbwe; memwb_rd_i = vt[i].wbrd;
      memwb_result_i = vt[i].wbres;
      tick();
      memwb_reg_write_i = 1'b0; memwb_rd_i = '0;
      #1;
      chk($sformatf("vec%0d valid", i), valid_o, 1);
      chk($sformatf("vec%0d src1", i), src1_o, vt[i].e1);
      chk($sformatf("vec%0d src2", i), src2_o, vt[i].e2);
      chk($sformatf("vec%0d store", i), store_data_o, vt[i].es);
      chk($sformatf("vec%0d ctrl", i), alu_ctrl_o, vt[i].ctrl);
    end

    // forwarding priority
    idle();
    issue(5'd8, 32'h88, 5'd1, 32'h1, 5'd12, 4'b0000, 1'b0);
    tick();
    exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd8;
    exmem_result_i = 32'h11;
    memwb_reg_write_i = 1'b1; memwb_rd_i = 5'd8;
    memwb_result_i = 32'h22;
    #1 chk("fwd exmem prio", src1_o, 32'h11);
    exmem_reg_write_i = 1'b0;
    #1 chk("fwd memwb", src1_o, 32'h22);
    exmem_reg_write_i = 1'b1; exmem_rd_i = '0; memwb_rd_i = '0;
    #1 chk("fwd r0 stored", src1_o, 32'h88);

    // load-use
    idle();
    issue(5'd1, 32'h1, 5'd2, 32'h2, 5'd9, 4'b1001, 1'b1);
    alu_src_i = 1'b1;
    tick();
    issue(5'd2, 32'h2, 5'd9, 32'h0, 5'd11, 4'b0000, 1'b0);
    uses_rt_i = 1'b0;
    #1 chk("lu rt unused", stall_req_o, 0);
    uses_rt_i = 1'b1;
    #1 chk("lu rt used", stall_req_o, 1);
    issue(5'd9, 32'h1111, 5'd2, 32'h2, 5'd11, 4'b0000, 1'b0);
    #1 chk("lu rs stall_req", stall_req_o, 1);
    chk("lu load mem_read", mem_read_o, 1);
    tick();
    chk("lu bubble valid", valid_o, 0);
    chk("lu bubble reg_write", reg_write_o, 0);
    chk("lu bubble stall_req", stall_req_o, 0);
    memwb_reg_write_i = 1'b1; memwb_rd_i = 5'd9;
    memwb_result_i = 32'h999;
    tick();
    chk("lu capture valid", valid_o, 1);
    chk("lu capture src1", src1_o, 32'h999);
    memwb_result_i = 32'h777;
    #1 chk("lu fwd src1", src1_o, 32'h777);

    // stall, flush+stall, reset during stall
    idle();
    issue(5'd3, 32'h33, 5'd4, 32'h44, 5'd12, 4'b0110, 1'b0);
    tick();
    issue(5'd5, 32'h55, 5'd6, 32'h66, 5'd13, 4'b0010, 1'b0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d valid", i), valid_o, 1);
      chk($sformatf("stall%0d src1", i), src1_o, 32'h33);
      chk($sformatf("stall%0d ctrl", i), alu_ctrl_o, 4'b0110);
      chk($sformatf("stall%0d rd", i), rd_addr_o, 5'd12);
    end
    flush_i = 1'b1;
    tick();
    chk("flush+stall valid", valid_o, 0);
    chk("flush+stall reg_write", reg_write_o, 0);
    flush_i = 1'b0; stall_i = 1'b0;
    tick();
    chk("recapture valid", valid_o, 1);
    stall_i = 1'b1; rst_n_i = 1'b0;
    tick();
    chk("rst+stall valid", valid_o, 0);
    chk("rst+stall ctrl", alu_ctrl_o, 0);
    chk("rst+stall rd", rd_addr_o, 0);
    chk("rst+stall src1", src1_o, 0);
    chk("rst+stall stall_req", stall_req_o, 0);

    // random traffic against the model
    idle();
    rst_n_i = 1'b0;
    tick();
    m = '0;
    for (int c = 0; c < 400; c++) begin
      rst_n_i = ($urandom_range(0, 49) != 0);
      flush_i = ($urandom_range(0, 11) == 0);
      stall_i = ($urandom_range(0, 7) == 0);
      valid_i = ($urandom_range(0, 3) != 0);
      rs_addr_i = 5'($urandom_range(0, 3));
      rt_addr_i = 5'($urandom_range(0, 3));
      rd_addr_i = 5'($urandom_range(0, 3));
      rs_data_i = $urandom; rt_data_i = $urandom;
      imm_i = 16'($urandom);
      ext_op_i = 1'($urandom); alu_src_i = 1'($urandom);
      uses_rt_i = 1'($urandom);
      alu_ctrl_i = ($urandom_range(0, 3) == 0) ? 4'b1011
                                               : 4'($urandom);
      reg_write_i = 1'($urandom);
      mem_read_i = ($urandom_range(0, 2) == 0);
      mem_write_i = 1'($urandom);
      exmem_reg_write_i = 1'($urandom);
      exmem_rd_i = 5'($urandom_range(0, 3));
      exmem_result_i = $urandom;
      memwb_reg_write_i = 1'($urandom);
      memwb_rd_i = 5'($urandom_range(0, 3));
      memwb_result_i = $urandom;
      #2;
      chk($sformatf("r%0d valid", c), valid_o, m.v);
      chk($sformatf("r%0d reg_write", c), reg_write_o, m.v & m.rw);
      chk($sformatf("r%0d mem_read", c), mem_read_o, m.v & m.mr);
      chk($sformatf("r%0d mem_write", c), mem_write_o, m.v & m.mw);
      chk($sformatf("r%0d stall_req", c), stall_req_o, hazard_exp());
      if (m.v) begin
        chk($sformatf("r%0d src1", c), src1_o, fwd_exp(m.rs, m.rsv));
        chk($sformatf("r%0d src2", c), src2_o,
            m.asrc ? m.imm : fwd_exp(m.rt, m.rtv));
        chk($sformatf("r%0d store", c), store_data_o,
            fwd_exp(m.rt, m.rtv));
        chk($sformatf("r%0d ctrl", c), alu_ctrl_o, m.ctrl);
        chk($sformatf("r%0d rd", c), rd_addr_o, m.rd);
      end
      @(posedge clk_i);
      m = model_next();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
